// File: rtl/pio_vga_pkg.sv
// ---------------------------------------------------------------------------
// pio_vga_pkg
// Shared definitions for the HPS pixel-write PIO responder.
//   ADDR_W   : pixel address width (640x480 framebuffer needs 19 bits)
//   DATA_W   : pixel data width
//   FB_WORDS : framebuffer size in pixels, used by the optional bounds check
//   state_t  : handshake FSM state encoding
//   pix_wr_t : one buffered pixel write {addr, data}
// ---------------------------------------------------------------------------
package pio_vga_pkg;

   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 8;
   localparam int FB_WORDS = 307200;

   typedef enum logic [1:0] {
      S_READY = 2'd0,
      S_ACK   = 2'd1,
      S_STALL = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } pix_wr_t;

endpackage

// File: rtl/pio_vga_fifo.sv
// ---------------------------------------------------------------------------
// pio_vga_fifo
// Synchronous show-ahead FIFO of pix_wr_t. The head entry is visible on dout
// whenever the FIFO is not empty; pop consumes it at the clock edge.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes contents)
//   push, din  : write one entry (ignored when full)
//   pop        : consume the head entry (ignored when empty)
//   dout       : head entry
//   empty/full : occupancy flags
//   level      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module pio_vga_fifo
   import pio_vga_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  pix_wr_t                din,
   input  logic                   pop,
   output pix_wr_t                dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   pix_wr_t            mem_q [DEPTH];
   pix_wr_t            mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               push_ok, pop_ok;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_W'(DEPTH));
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];
   assign level   = level_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the level unchanged.
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
      // Storage needs no reset: stale entries are never visible once the
      // level is cleared.
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pio_vga_write_responder.sv
// ---------------------------------------------------------------------------
// pio_vga_write_responder
// Accepts pixel writes from the HPS PIO through a four-phase handshake on
// pio_vga_we / pio_mem_rdy, buffers them in a show-ahead FIFO and drains
// them in order to the framebuffer write port (fb_we held until fb_ready).
// Ports:
//   clk_clk, reset_reset       : system clock, synchronous active-high reset
//   pio_vga_addr/data/we       : pixel write request from software
//   pio_mem_rdy                : ready flag back to software
//   fb_addr/fb_data/fb_we      : framebuffer write request
//   fb_ready                   : framebuffer accepts the request this cycle
//   fifo_level                 : current FIFO occupancy
//   drop_cnt                   : saturating count of out-of-range writes
// Optional feature: PIO_VGA_BOUNDS_CHECK_EN drops writes with
// addr >= FB_WORDS and counts them; otherwise drop_cnt is tied to 0.
// Handshake: a write is captured on the rising edge of pio_vga_we while
// pio_mem_rdy is high; pio_mem_rdy drops the next cycle and returns only
// after pio_vga_we is seen low and the FIFO has room.
// ---------------------------------------------------------------------------
module pio_vga_write_responder
   import pio_vga_pkg::*;
#(
   parameter int ADDR_W     = pio_vga_pkg::ADDR_W,
   parameter int DATA_W     = pio_vga_pkg::DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int FB_WORDS   = pio_vga_pkg::FB_WORDS
) (
   input  logic                        clk_clk,
   input  logic                        reset_reset,
   input  logic [ADDR_W-1:0]           pio_vga_addr,
   input  logic [DATA_W-1:0]           pio_vga_data,
   input  logic                        pio_vga_we,
   output logic                        pio_mem_rdy,
   output logic [ADDR_W-1:0]           fb_addr,
   output logic [DATA_W-1:0]           fb_data,
   output logic                        fb_we,
   input  logic                        fb_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0]                 drop_cnt
);

   // The FIFO payload type is fixed by the package widths.
   if (ADDR_W != pio_vga_pkg::ADDR_W || DATA_W != pio_vga_pkg::DATA_W ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       FB_WORDS < 1) begin : g_bad_cfg
      $error("pio_vga_write_responder: unsupported parameter set");
   end

   state_t   state_q, state_d;
   logic     we_q, we_d;
   logic     rdy_q, rdy_d;
   logic     we_rise;
   logic     capture;
   logic     push;
   logic     pop;
   pix_wr_t  wr_in;
   pix_wr_t  head;
   logic     fifo_empty;
   logic     fifo_full;

   // we_q resets to 1 so a strobe already high at reset release is ignored.
   assign we_d    = pio_vga_we;
   assign we_rise = pio_vga_we & ~we_q;
   assign capture = (state_q == S_READY) & we_rise;

   assign wr_in.addr = pio_vga_addr;
   assign wr_in.data = pio_vga_data;

`ifdef PIO_VGA_BOUNDS_CHECK_EN
   localparam logic [31:0] FB_LIMIT = 32'(FB_WORDS);

   logic        in_range;
   logic [15:0] drop_q, drop_d;

   assign in_range = (32'(pio_vga_addr) < FB_LIMIT);
   assign push     = capture & in_range;

   always_comb begin
      drop_d = drop_q;
      if (capture && !in_range && drop_q != 16'hFFFF) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) drop_q <= '0;
      else             drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;
`else
   assign push     = capture;
   assign drop_cnt = '0;
`endif

   // Handshake FSM. S_READY is only entered with free FIFO space, so a
   // capture in S_READY can always be pushed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_READY: if (we_rise)     state_d = S_ACK;
         S_ACK:   if (!pio_vga_we) state_d = fifo_full ? S_STALL : S_READY;
         S_STALL: if (!fifo_full)  state_d = S_READY;
         default:                  state_d = S_READY;
      endcase
      rdy_d = (state_d == S_READY);
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= S_READY;
         we_q    <= 1'b1;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         rdy_q   <= rdy_d;
      end
   end

   assign pio_mem_rdy = rdy_q;

   pio_vga_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .push  (push),
      .din   (wr_in),
      .pop   (pop),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (fifo_level)
   );

   // Show-ahead drain; outputs are forced to zero while nothing is pending.
   assign fb_we   = ~fifo_empty;
   assign pop     = fb_we & fb_ready;
   assign fb_addr = fifo_empty ? '0 : head.addr;
   assign fb_data = fifo_empty ? '0 : head.data;

endmodule
